// File: rtl/organ_note_scheduler.sv
// rtl/organ_note_scheduler.sv - selects the organ divider count from the manual keyboard or the auto scale player
module organ_note_scheduler #(
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2_500_000
) (
    input  logic        inclk,
    input  logic        Reset,
    input  logic        manual_en,
    input  logic [2:0]  manual_note,
    input  logic        manual_gate,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    output logic [31:0] div_clk_count,
    output logic        tone_en,
    output logic [2:0]  note_idx,
    output logic        busy,
    output logic        note_strobe
);
    typedef enum logic [1:0] {IDLE, NOTE, GAP, MANUAL} state_t;

    localparam logic [31:0] NOTE_LAST   = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST    = 32'(GAP_TICKS - 1);
    localparam logic [31:0] RESET_COUNT = 32'd47800;

    // floor(50 MHz / (2 * f)) - 1 for the C5..C6 major scale
    function automatic logic [31:0] note_count(input logic [2:0] idx);
        case (idx)
            3'd0:    note_count = 32'd47800;
            3'd1:    note_count = 32'd42588;
            3'd2:    note_count = 32'd37935;
            3'd3:    note_count = 32'd35815;
            3'd4:    note_count = 32'd31927;
            3'd5:    note_count = 32'd28408;
            3'd6:    note_count = 32'd25328;
            default: note_count = 32'd23899;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [2:0]  pos_q, pos_d;
    logic [2:0]  idx_q, idx_d;
    logic        tone_q, tone_d;
    logic        busy_q, busy_d;
    logic [31:0] div_q, div_d;
    logic        strobe_q, strobe_d;
    logic        note_done, gap_done;

    assign note_done = (state_q == NOTE) && (timer_q == NOTE_LAST);
    assign gap_done  = (state_q == GAP) && (timer_q == GAP_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        pos_d   = pos_q;
        idx_d   = idx_q;
        tone_d  = tone_q;
        busy_d  = busy_q;
        if (manual_en) begin
            // the entry edge only aborts the sequence; keys are followed from the next edge
            state_d = MANUAL;
            timer_d = 32'd0;
            pos_d   = 3'd0;
            busy_d  = 1'b0;
            if (state_q == MANUAL) begin
                idx_d  = manual_note;
                tone_d = manual_gate;
            end else begin
                tone_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = 32'd0;
                    tone_d  = 1'b0;
                    busy_d  = 1'b0;
                    if (start && !stop) begin
                        state_d = NOTE;
                        pos_d   = 3'd0;
                        idx_d   = 3'd0;
                        tone_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                NOTE, GAP: begin
                    if (stop) begin
                        state_d = IDLE;
                        timer_d = 32'd0;
                        pos_d   = 3'd0;
                        tone_d  = 1'b0;
                        busy_d  = 1'b0;
                    end else if (note_done && GAP_TICKS != 0) begin
                        state_d = GAP;
                        timer_d = 32'd0;
                        tone_d  = 1'b0;
                    end else if (note_done || gap_done) begin
                        timer_d = 32'd0;
                        if (pos_q != 3'd7) begin
                            state_d = NOTE;
                            pos_d   = pos_q + 3'd1;
                            idx_d   = pos_q + 3'd1;
                            tone_d  = 1'b1;
                        end else if (loop_en) begin
                            state_d = NOTE;
                            pos_d   = 3'd0;
                            idx_d   = 3'd0;
                            tone_d  = 1'b1;
                        end else begin
                            state_d = IDLE;
                            pos_d   = 3'd0;
                            tone_d  = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = 32'd0;
                    tone_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
        div_d    = note_count(idx_d);
        strobe_d = (div_d != div_q);
    end

    always_ff @(posedge inclk) begin
        if (Reset) begin
            state_q  <= IDLE;
            timer_q  <= 32'd0;
            pos_q    <= 3'd0;
            idx_q    <= 3'd0;
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
            div_q    <= RESET_COUNT;
            strobe_q <= (div_q != RESET_COUNT);
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pos_q    <= pos_d;
            idx_q    <= idx_d;
            tone_q   <= tone_d;
            busy_q   <= busy_d;
            div_q    <= div_d;
            strobe_q <= strobe_d;
        end
    end

    assign div_clk_count = div_q;
    assign tone_en       = tone_q;
    assign note_idx      = idx_q;
    assign busy          = busy_q;
    assign note_strobe   = strobe_q;
endmodule

// File: tb/tb_organ_note_scheduler.sv
// tb/tb_organ_note_scheduler.sv - randomized self-checking bench for organ_note_scheduler
module tb_organ_note_scheduler;
    localparam int NT  = 4;
    localparam int GT  = 2;
    localparam int PER = NT + GT;

    logic        inclk = 1'b0;
    logic        Reset, manual_en, manual_gate, start, stop, loop_en;
    logic [2:0]  manual_note;
    logic [31:0] div_clk_count;
    logic        tone_en, busy, note_strobe;
    logic [2:0]  note_idx;

    int          total = 0;
    int          bad = 0;
    int          freq [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};
    logic [31:0] tbl [8];
    logic [31:0] prev_div;

    always #5 inclk = ~inclk;

    organ_note_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .inclk(inclk), .Reset(Reset), .manual_en(manual_en), .manual_note(manual_note),
        .manual_gate(manual_gate), .start(start), .stop(stop), .loop_en(loop_en),
        .div_clk_count(div_clk_count), .tone_en(tone_en), .note_idx(note_idx),
        .busy(busy), .note_strobe(note_strobe)
    );

    task automatic step();
        @(posedge inclk);
        #1;
    endtask

    // {idx, tone, busy} t edges after the edge that accepted start
    function automatic logic [4:0] auto_model(int t, bit loop);
        int n = t / PER;
        if (!loop && n >= 8) return {3'd7, 1'b0, 1'b0};
        return {3'(n % 8), (t % PER) < NT, 1'b1};
    endfunction

    function automatic logic [37:0] pack_exp(logic [2:0] idx, logic tone, logic bsy);
        return {idx, tbl[idx], tone, bsy, tbl[idx] != prev_div};
    endfunction

    task automatic test_reset();
        logic [37:0] got, exp;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) step();
            Reset = 1'b0;
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            exp = {3'd0, tbl[0], 1'b0, 1'b0, 1'b0};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset c=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         c, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
    endtask

    task automatic test_scale_once();
        logic [37:0] got, exp;
        logic [4:0]  m;
        loop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 8 * PER + 2; t++) begin
            if (t > 0) step();
            m = auto_model(t, 1'b0);
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL scale_once t=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
    endtask

    task automatic test_loop_random_stop();
        logic [37:0] got, exp;
        logic [4:0]  m;
        int          stop_t;
        logic [2:0]  last_idx;
        stop_t = $urandom_range(8 * PER + 1, 8 * PER + 30);
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= stop_t; t++) begin
            if (t > 0) step();
            stop = 1'b0;
            if (t < stop_t) begin
                m = auto_model(t, 1'b1);
                last_idx = m[4:2];
            end else begin
                m = {last_idx, 1'b0, 1'b0};
            end
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL loop_stop t=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
            if (t == stop_t - 1) stop = 1'b1;
        end
        loop_en = 1'b0;
    endtask

    task automatic test_manual_override();
        logic [37:0] got, exp;
        logic [4:0]  m;
        logic [2:0]  n;
        logic        g;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (t > 0) step();
            m = auto_model(t, 1'b0);
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL manual_pre t=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
        manual_en = 1'b1;
        manual_note = 3'd5;
        manual_gate = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL manual_entry_busy got=%0b want=0", busy);
        end
        for (int c = 0; c < 17; c++) begin
            n = manual_note;
            g = manual_gate;
            step();
            exp = pack_exp(n, g, 1'b0);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL manual c=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         c, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
            manual_note = 3'($urandom_range(0, 7));
            manual_gate = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            stop = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        stop = 1'b0;
        manual_en = 1'b0;
        step();
        exp = pack_exp(n, 1'b0, 1'b0);
        got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL manual_exit got idx=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d tone=%0b busy=%0b strobe=%0b",
                     got[37:35], got[2], got[1], got[0], exp[37:35], exp[2], exp[1], exp[0]);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 14; t++) begin
            if (t > 0) step();
            m = auto_model(t, 1'b0);
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL manual_restart t=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        exp = pack_exp(3'd2, 1'b0, 1'b0);
        got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL manual_final_stop got idx=%0d tone=%0b busy=%0b want idx=%0d tone=%0b busy=%0b",
                     got[37:35], got[2], got[1], exp[37:35], exp[2], exp[1]);
        end
    endtask

    task automatic test_start_stop();
        logic [37:0] got, exp;
        logic [4:0]  m;
        logic [2:0]  held;
        held = note_idx === 3'd2 ? 3'd2 : 3'd2;
        start = 1'b1;
        stop = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            start = 1'b0;
            stop = 1'b0;
            exp = pack_exp(held, 1'b0, 1'b0);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL start_stop_idle c=%0d got idx=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d tone=%0b busy=%0b strobe=%0b",
                         c, got[37:35], got[2], got[1], got[0], exp[37:35], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 5; t++) begin
            if (t > 0) step();
            stop = 1'b0;
            m = (t < 5) ? auto_model(t, 1'b0) : {3'd0, 1'b0, 1'b0};
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL stop_in_gap t=%0d got idx=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[2], got[1], got[0], exp[37:35], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
            if (t == 4) stop = 1'b1;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (t > 0) step();
            start = 1'b0;
            m = auto_model(t, 1'b0);
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL start_ignored t=%0d got idx=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[2], got[1], got[0], exp[37:35], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
            if (t == 2 || t == 8) start = 1'b1;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        prev_div = tbl[2];
    endtask

    task automatic test_reset_mid_note();
        logic [37:0] got, exp;
        logic [4:0]  m;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 0; t <= 25; t++) begin
            if (t > 0) step();
            m = auto_model(t, 1'b0);
            exp = pack_exp(m[4:2], m[1], m[0]);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL pre_reset t=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         t, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
        Reset = 1'b1;
        start = 1'b1;
        manual_en = 1'b1;
        stop = 1'($urandom_range(0, 1));
        for (int c = 0; c < 3; c++) begin
            step();
            Reset = 1'b0;
            start = 1'b0;
            manual_en = 1'b0;
            stop = 1'b0;
            exp = pack_exp(3'd0, 1'b0, 1'b0);
            got = {note_idx, div_clk_count, tone_en, busy, note_strobe};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_mid_note c=%0d got idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b want idx=%0d div=%0d tone=%0b busy=%0b strobe=%0b",
                         c, got[37:35], got[34:3], got[2], got[1], got[0], exp[37:35], exp[34:3], exp[2], exp[1], exp[0]);
            end
            prev_div = exp[34:3];
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tbl[i] = 32'(50_000_000 / (2 * freq[i]) - 1);
        prev_div = tbl[0];
        Reset = 1'b1;
        manual_en = 1'b0;
        manual_note = 3'd0;
        manual_gate = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        repeat (3) step();
        test_reset();
        test_scale_once();
        test_loop_random_stop();
        test_manual_override();
        test_start_stop();
        test_reset_mid_note();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
